// File: rtl/alu_seq_ctrl.sv
// Registered ALU control decoder with an iterative unsigned multiply/divide engine and HI/LO.
// Define ALU_SEQ_DIV_EN to build the restoring divider; otherwise div decodes as illegal.
module alu_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [2:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [3:0]       ALUCtrl,
   output logic             illegal,
   output logic             stall,
   output logic             md_done,
   output logic             div_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t           r_state;
   logic [3:0]       r_aluctrl;
   logic             r_illegal, r_stall, r_md_done;
   logic [WIDTH-1:0] r_hi_out, r_lo_out;
   logic [WIDTH-1:0] r_a, r_hi, r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       w_fcode, w_code;
   logic             w_last;
   logic [WIDTH:0]   w_msum;
   logic [WIDTH-1:0] w_mhi, w_mlo;

   always_comb begin
      w_fcode = 4'd15;
      case (Funct)
         6'b100100: w_fcode = 4'd0;
         6'b100101: w_fcode = 4'd1;
         6'b100000: w_fcode = 4'd2;
         6'b100010: w_fcode = 4'd3;
         6'b101010: w_fcode = 4'd4;
         6'b111010: w_fcode = 4'd5;
         6'b011000: w_fcode = 4'd7;
`ifdef ALU_SEQ_DIV_EN
         6'b011010: w_fcode = 4'd8;
`endif
         6'b000000: w_fcode = 4'd9;
         6'b000001: w_fcode = 4'd10;
         6'b101011: w_fcode = 4'd11;
         6'b111011: w_fcode = 4'd12;
         6'b000010: w_fcode = 4'd13;
         6'b000011: w_fcode = 4'd14;
         default:   w_fcode = 4'd15;
      endcase
   end

   always_comb begin
      w_code = 4'd15;
      case (ALUOp)
         3'b000:  w_code = 4'd2;
         3'b001:  w_code = 4'd3;
         3'b010:  w_code = 4'd4;
         3'b011:  w_code = 4'd5;
         3'b100:  w_code = 4'd6;
         3'b101:  w_code = w_fcode;
         default: w_code = 4'd15;
      endcase
   end

   assign w_last = (r_cnt == CNT_W'(WIDTH-1));

   // {r_hi,r_lo} is the product register; r_lo starts as the multiplier and shifts out LSB first
   assign w_msum = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_a});
   assign w_mhi  = w_msum[WIDTH:1];
   assign w_mlo  = {w_msum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH-1:0] r_b;
   logic             r_div_zero;
   logic [WIDTH:0]   w_dpart;
   logic             w_qbit;
   logic [WIDTH-1:0] w_drem, w_dhi, w_dlo;

   // r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in
   assign w_dpart = {r_hi, r_lo[WIDTH-1]};
   assign w_qbit  = (w_dpart >= {1'b0, r_b});
   assign w_drem  = WIDTH'(w_dpart - {1'b0, r_b});
   assign w_dhi   = w_qbit ? w_drem : w_dpart[WIDTH-1:0];
   assign w_dlo   = {r_lo[WIDTH-2:0], w_qbit};
   assign div_zero = r_div_zero;
`else
   assign div_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_aluctrl <= '0;
         r_illegal <= 1'b0;
         r_stall   <= 1'b0;
         r_md_done <= 1'b0;
         r_hi_out  <= '0;
         r_lo_out  <= '0;
         r_a       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
`ifdef ALU_SEQ_DIV_EN
         r_b        <= '0;
         r_div_zero <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state   <= S_IDLE;
               r_stall   <= 1'b0;
               r_md_done <= 1'b0;
               if (valid_in) begin
                  r_aluctrl <= w_code;
                  r_illegal <= (w_code == 4'd15);
                  if (w_code == 4'd7) begin
                     r_state <= S_MULT;
                     r_stall <= 1'b1;
                     r_a     <= A;
                     r_hi    <= '0;
                     r_lo    <= B;
                     r_cnt   <= '0;
                  end
`ifdef ALU_SEQ_DIV_EN
                  else if (w_code == 4'd8) begin
                     if (B != '0) begin
                        r_state <= S_DIV;
                        r_stall <= 1'b1;
                        r_b     <= B;
                        r_hi    <= '0;
                        r_lo    <= A;
                        r_cnt   <= '0;
                     end else begin
                        r_state    <= S_DONE;
                        r_md_done  <= 1'b1;
                        r_hi_out   <= A;
                        r_lo_out   <= '1;
                        r_div_zero <= 1'b1;
                     end
                  end
`endif
               end
            end
            S_MULT: begin
               r_hi <= w_mhi;
               r_lo <= w_mlo;
               if (r_cnt != CNT_W'(WIDTH)) r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state   <= S_DONE;
                  r_stall   <= 1'b0;
                  r_md_done <= 1'b1;
                  r_hi_out  <= w_mhi;
                  r_lo_out  <= w_mlo;
               end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
               r_hi <= w_dhi;
               r_lo <= w_dlo;
               if (r_cnt != CNT_W'(WIDTH)) r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state    <= S_DONE;
                  r_stall    <= 1'b0;
                  r_md_done  <= 1'b1;
                  r_hi_out   <= w_dhi;
                  r_lo_out   <= w_dlo;
                  r_div_zero <= 1'b0;
               end
            end
`endif
            default: begin
               r_state   <= S_IDLE;
               r_stall   <= 1'b0;
               r_md_done <= 1'b0;
            end
         endcase
      end
   end

   assign ALUCtrl = r_aluctrl;
   assign illegal = r_illegal;
   assign stall   = r_stall;
   assign md_done = r_md_done;
   assign HI      = r_hi_out;
   assign LO      = r_lo_out;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl at WIDTH=8; divider cases follow ALU_SEQ_DIV_EN.
module tb_alu_seq_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0, rst = 1'b1, valid_in = 1'b0;
   logic [2:0]   ALUOp = '0;
   logic [5:0]   Funct = '0;
   logic [W-1:0] A = '0, B = '0;
   logic [3:0]   ALUCtrl;
   logic         illegal, stall, md_done, div_zero;
   logic [W-1:0] HI, LO;

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ALUOp(ALUOp), .Funct(Funct),
      .A(A), .B(B), .ALUCtrl(ALUCtrl), .illegal(illegal), .stall(stall),
      .md_done(md_done), .div_zero(div_zero), .HI(HI), .LO(LO));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;

   typedef struct {int stamp; logic [3:0] code; logic ill;} dec_t;
   typedef struct {int stamp; logic [W-1:0] hi; logic [W-1:0] lo; logic dz;} md_t;
   dec_t dec_q[$];
   md_t  md_q[$];
   dec_t dm;
   md_t  mm;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: decode results are due at a stamped cycle; md results whenever md_done shows.
   always @(negedge clk) begin
      if (dec_q.size() > 0 && dec_q[0].stamp <= cyc) begin
         dm = dec_q.pop_front();
         chk("dec_cycle", cyc, dm.stamp);
         chk("ALUCtrl", {28'd0, ALUCtrl}, {28'd0, dm.code});
         chk("illegal", {31'd0, illegal}, {31'd0, dm.ill});
      end
      if (md_done) begin
         if (md_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL md_unexpected: got md_done=1 expected 0 (cycle %0d)", cyc);
         end else begin
            mm = md_q.pop_front();
            chk("md_cycle", cyc, mm.stamp);
            chk("HI", {24'd0, HI}, {24'd0, mm.hi});
            chk("LO", {24'd0, LO}, {24'd0, mm.lo});
            chk("div_zero", {31'd0, div_zero}, {31'd0, mm.dz});
         end
      end else if (md_q.size() > 0 && md_q[0].stamp < cyc) begin
         mm = md_q.pop_front();
         n_chk++; n_err++;
         $display("FAIL md_missing: got no md_done expected one at cycle %0d", mm.stamp);
      end
   end

   task automatic issue(input logic [2:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] code);
      valid_in = 1'b1; ALUOp = op; Funct = f; A = a; B = b;
      dec_q.push_back('{cyc + 1, code, (code == 4'd15)});
   endtask

   task automatic wait_done(input int bound, output int sc, output bit seen);
      sc = 0; seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         valid_in = 1'b0;
         if (stall) sc++;
         if (md_done) begin seen = 1'b1; break; end
      end
   endtask

   typedef struct {logic [2:0] op; logic [5:0] f; logic [3:0] code;} vec_t;
   vec_t tbl[$] = '{
      '{3'b101, 6'b100010, 4'd3},  '{3'b111, 6'b000000, 4'd15}, '{3'b101, 6'b111111, 4'd15},
      '{3'b000, 6'b000000, 4'd2},  '{3'b001, 6'b000000, 4'd3},  '{3'b010, 6'b000000, 4'd4},
      '{3'b011, 6'b000000, 4'd5},  '{3'b100, 6'b000000, 4'd6},  '{3'b110, 6'b100000, 4'd15},
      '{3'b101, 6'b100100, 4'd0},  '{3'b101, 6'b100101, 4'd1},  '{3'b101, 6'b100000, 4'd2},
      '{3'b101, 6'b101010, 4'd4},  '{3'b101, 6'b111010, 4'd5},  '{3'b101, 6'b000000, 4'd9},
      '{3'b101, 6'b000001, 4'd10}, '{3'b101, 6'b101011, 4'd11}, '{3'b101, 6'b111011, 4'd12},
      '{3'b101, 6'b000010, 4'd13}, '{3'b101, 6'b000011, 4'd14}};

   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;

   initial begin
      int  sc;
      bit  seen;
      bit  any_stall;

      repeat (3) @(negedge clk);
      chk("rst_ALUCtrl", {28'd0, ALUCtrl}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_md_done", {31'd0, md_done}, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      chk("rst_HI", {24'd0, HI}, 32'd0);
      chk("rst_LO", {24'd0, LO}, 32'd0);
      rst = 1'b0;

      // back-to-back decode requests; none of these may stall
      any_stall = 1'b0;
      foreach (tbl[i]) begin
         @(negedge clk);
         any_stall |= stall;
         issue(tbl[i].op, tbl[i].f, 8'h12, 8'h34, tbl[i].code);
      end
      repeat (3) begin
         @(negedge clk);
         valid_in = 1'b0;
         any_stall |= stall;
      end
      chk("decode_no_stall", {31'd0, any_stall}, 32'd0);

      // 13*11 = 143
      @(negedge clk);
      issue(3'b101, F_MULT, 8'd13, 8'd11, 4'd7);
      md_q.push_back('{cyc + 1 + W, 8'h00, 8'h8F, 1'b0});
      wait_done(20, sc, seen);
      chk("mult1_stall_cycles", sc, W);
      chk("mult1_done_seen", {31'd0, seen}, 32'd1);

      // 255*255 = 0xFE01
      @(negedge clk);
      issue(3'b101, F_MULT, 8'hFF, 8'hFF, 4'd7);
      md_q.push_back('{cyc + 1 + W, 8'hFE, 8'h01, 1'b0});
      wait_done(20, sc, seen);
      chk("mult2_stall_cycles", sc, W);
      chk("mult2_done_seen", {31'd0, seen}, 32'd1);

`ifdef ALU_SEQ_DIV_EN
      // 200/7 = 28 r 4
      @(negedge clk);
      issue(3'b101, F_DIV, 8'd200, 8'd7, 4'd8);
      md_q.push_back('{cyc + 1 + W, 8'd4, 8'd28, 1'b0});
      wait_done(20, sc, seen);
      chk("div1_stall_cycles", sc, W);
      chk("div1_done_seen", {31'd0, seen}, 32'd1);

      // divide by zero completes immediately without stalling
      @(negedge clk);
      issue(3'b101, F_DIV, 8'd9, 8'd0, 4'd8);
      md_q.push_back('{cyc + 1, 8'd9, 8'hFF, 1'b1});
      wait_done(20, sc, seen);
      chk("div0_stall_cycles", sc, 0);
      chk("div0_done_seen", {31'd0, seen}, 32'd1);

      // div then mult issued in the div's DONE cycle
      @(negedge clk);
      issue(3'b101, F_DIV, 8'd200, 8'd7, 4'd8);
      md_q.push_back('{cyc + 1 + W, 8'd4, 8'd28, 1'b0});
      wait_done(20, sc, seen);
      chk("b2b_div_done_seen", {31'd0, seen}, 32'd1);
      issue(3'b101, F_MULT, 8'd13, 8'd11, 4'd7);
      md_q.push_back('{cyc + 1 + W, 8'h00, 8'h8F, 1'b0});
      wait_done(20, sc, seen);
      chk("b2b_mult_stall_cycles", sc, W);
      chk("b2b_mult_done_seen", {31'd0, seen}, 32'd1);
`else
      // div is illegal in this build and must not start anything
      @(negedge clk);
      issue(3'b101, F_DIV, 8'd200, 8'd7, 4'd15);
      wait_done(12, sc, seen);
      chk("nodiv_stall_cycles", sc, 0);
      chk("nodiv_done_seen", {31'd0, seen}, 32'd0);

      // mult then mult issued in the first one's DONE cycle
      @(negedge clk);
      issue(3'b101, F_MULT, 8'd13, 8'd11, 4'd7);
      md_q.push_back('{cyc + 1 + W, 8'h00, 8'h8F, 1'b0});
      wait_done(20, sc, seen);
      chk("b2b_first_done_seen", {31'd0, seen}, 32'd1);
      issue(3'b101, F_MULT, 8'hFF, 8'hFF, 4'd7);
      md_q.push_back('{cyc + 1 + W, 8'hFE, 8'h01, 1'b0});
      wait_done(20, sc, seen);
      chk("b2b_second_stall_cycles", sc, W);
      chk("b2b_second_done_seen", {31'd0, seen}, 32'd1);
`endif

      // reset during the 4th MULT cycle aborts with no md_done
      @(negedge clk);
      issue(3'b101, F_MULT, 8'd13, 8'd11, 4'd7);
      repeat (4) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
      chk("abort_stall_before", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ALUCtrl", {28'd0, ALUCtrl}, 32'd0);
      chk("abort_illegal", {31'd0, illegal}, 32'd0);
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_md_done", {31'd0, md_done}, 32'd0);
      chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
      chk("abort_HI", {24'd0, HI}, 32'd0);
      chk("abort_LO", {24'd0, LO}, 32'd0);
      wait_done(12, sc, seen);
      chk("abort_no_stall_after", sc, 0);
      chk("abort_no_done_after", {31'd0, seen}, 32'd0);

      repeat (3) @(negedge clk);
      chk("dec_q_drained", dec_q.size(), 0);
      chk("md_q_drained", md_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish by 100000");
      $fatal(1);
   end
endmodule
